// File: rtl/thor2024_regfile_ram.sv
// thor2024_regfile_ram: simple dual-port byte-writable RAM with a registered read address.
// The read is combinational from raddr, so writes to mem[raddr] show on doutb at the write edge.
module thor2024_regfile_ram #(
    parameter int WID = 64,
    parameter int RBIT = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [WID/8-1:0]     wea,
    input  logic [RBIT:0]        addra,
    input  logic [WID-1:0]       dina,
    input  logic                 enb,
    input  logic [RBIT:0]        addrb,
    output logic [WID-1:0]       doutb
);
    logic [WID-1:0] mem [0:(1<<(RBIT+1))-1] = '{default: '0};
    logic [RBIT:0] raddr;
    always_ff @(posedge clk)
        if (ena)
            for (int i = 0; i < WID/8; i++)
                if (wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
    always_ff @(posedge clk or posedge rst)
        if (rst) raddr <= '0;
        else if (enb) raddr <= addrb;
    assign doutb = mem[raddr];
endmodule

// File: tb/tb_thor2024_regfile_ram.sv
// tb_thor2024_regfile_ram: directed and random checks of the RAM against an array model.
module tb_thor2024_regfile_ram;
    logic clk = 0, rst = 1, ena = 0, enb = 0;
    logic [7:0] wea = 0;
    logic [11:0] addra = 0, addrb = 0;
    logic [63:0] dina = 0, doutb;
    logic [63:0] ref_mem [0:4095];
    logic [11:0] m_raddr = 0;
    int n_assert = 0, n_fail = 0;

    thor2024_regfile_ram dut (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .enb(enb), .addrb(addrb), .doutb(doutb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] exp);
        n_assert++;
        assert (doutb === exp) else begin
            n_fail++;
            $error("FAIL %s: doutb=%h expected=%h", tag, doutb, exp);
        end
    endtask

    // Apply one clock of stimulus, then advance the model by the same edge.
    task automatic cyc(input logic e, input logic [7:0] w, input logic [11:0] aa,
                       input logic [63:0] d, input logic eb, input logic [11:0] ab);
        logic [63:0] mask;
        ena = e; wea = w; addra = aa; dina = d; enb = eb; addrb = ab;
        @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) mask[8*k +: 8] = {8{w[k]}};
        if (e) ref_mem[aa] = (ref_mem[aa] & ~mask) | (d & mask);
        if (rst) m_raddr = 0;
        else if (eb) m_raddr = ab;
    endtask

    initial begin
        logic [11:0] a1, a2;
        foreach (ref_mem[i]) ref_mem[i] = 0;
        cyc(0, 0, 0, 0, 1, 12'h123);
        chk("reset_state", 64'h0);
        rst = 0;
        cyc(0, 0, 0, 0, 1, 12'h000); chk("pwr_rd0", 64'h0);
        cyc(0, 0, 0, 0, 1, 12'h001); chk("pwr_rd1", 64'h0);
        cyc(0, 0, 0, 0, 1, 12'hFFF); chk("pwr_rdfff", 64'h0);
        cyc(1, 8'hFF, 12'h005, 64'h0123456789ABCDEF, 0, 0);
        cyc(0, 0, 0, 0, 1, 12'h005); chk("full_wr", 64'h0123456789ABCDEF);
        cyc(1, 8'h0F, 12'h005, 64'hFFFFFFFFFFFFFFFF, 0, 0); chk("byte_merge", 64'h01234567FFFFFFFF);
        cyc(0, 8'hFF, 12'h005, 64'h0, 0, 0); chk("ena0", 64'h01234567FFFFFFFF);
        cyc(1, 8'h00, 12'h005, 64'h0, 0, 0); chk("wea0", 64'h01234567FFFFFFFF);
        cyc(1, 8'hFF, 12'h010, 64'h1111111111111111, 1, 12'h010); chk("same_edge_wt", 64'h1111111111111111);
        cyc(0, 0, 0, 0, 0, 12'h005); chk("enb0_hold", 64'h1111111111111111);
        cyc(1, 8'hFF, 12'h010, 64'hAAAAAAAAAAAAAAAA, 0, 12'h007); chk("write_thru", 64'hAAAAAAAAAAAAAAAA);
        cyc(1, 8'hFF, 12'h000, 64'hDEADBEEFCAFEF00D, 0, 0); chk("raddr_kept", 64'hAAAAAAAAAAAAAAAA);
        #3 rst = 1;
        m_raddr = 0;
        #1 chk("async_rst", 64'hDEADBEEFCAFEF00D);
        cyc(1, 8'hFF, 12'h009, 64'h9999999999999999, 1, 12'h005); chk("rst_rd_ign", 64'hDEADBEEFCAFEF00D);
        #1 rst = 0;
        cyc(0, 0, 0, 0, 0, 12'h005); chk("post_rst_hold", 64'hDEADBEEFCAFEF00D);
        cyc(0, 0, 0, 0, 1, 12'h005); chk("post_rst_005", 64'h01234567FFFFFFFF);
        cyc(0, 0, 0, 0, 1, 12'h009); chk("rst_wr_kept", 64'h9999999999999999);
        cyc(1, 8'hFF, 12'hFFF, 64'h5A5A5A5A5A5A5A5A, 1, 12'hFFF); chk("top_addr", 64'h5A5A5A5A5A5A5A5A);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 19) == 0);
            if (rst) m_raddr = 0;
            a1 = $urandom_range(0, 15);
            a2 = $urandom_range(0, 15);
            a1 = a1 < 8 ? a1 : 12'hFF0 + a1;
            a2 = a2 < 8 ? a2 : 12'hFF0 + a2;
            cyc($urandom_range(0, 1), 8'($urandom), a1, {$urandom, $urandom}, $urandom_range(0, 1), a2);
            chk("random", ref_mem[m_raddr]);
        end
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            a1 = i < 8 ? 12'(i) : 12'(12'hFF0 + i);
            cyc(0, 0, 0, 0, 1, a1);
            chk("final_scan", ref_mem[a1]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/thor2024_regfile_ram.md
THOR2024_REGFILE_RAM -- requirements
Module: thor2024_regfile_ram

Interface
REQ-001 SHALL have parameter WID, default 64: data width in bits; a multiple of 8.
REQ-002 SHALL have parameter RBIT, default 11: address MSB index, so addresses are RBIT+1 bits wide.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all sequential logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ena, input, 1 bit: write-port enable.
REQ-006 SHALL have port wea, input, WID/8 bits: per-byte write enables; bit k controls data bits [8k+7:8k].
REQ-007 SHALL have port addra, input, RBIT+1 bits: write address.
REQ-008 SHALL have port dina, input, WID bits: write data.
REQ-009 SHALL have port enb, input, 1 bit: read-port enable.
REQ-010 SHALL have port addrb, input, RBIT+1 bits: read address.
REQ-011 SHALL have port doutb, output, WID bits: read data.

Function
REQ-012 SHALL implement a simple dual-port memory of 2^(RBIT+1) words x WID bits (default 4096 x 64).
REQ-013 SHALL be inferable as block RAM, with one write port and one read port.
REQ-014 SHALL initialise every memory word to 0 at power-up/configuration.
REQ-015 Memory contents SHALL NOT be altered by rst.
REQ-016 Write: on a rising clk edge with ena=1, each byte lane k with wea[k]=1 SHALL take dina byte k at mem[addra]; lanes with wea[k]=0 SHALL keep their value.
REQ-017 With ena=0 no write SHALL occur, regardless of wea.
REQ-018 wea=0 with ena=1 SHALL be a no-op.
REQ-019 Read: on a rising clk edge with enb=1, addrb SHALL be captured into an internal read-address register raddr.
REQ-020 With enb=0, raddr SHALL hold its value.
REQ-021 doutb SHALL equal mem[raddr] continuously; read latency is 1 clk from addrb to doutb.
REQ-022 Write-through: when a write updates mem[raddr], doutb SHALL reflect the new byte values right after that same write edge.
REQ-023 Write-through SHALL include the case where addra equals the addrb being captured on the same edge, so the new data appears in the first cycle after the edge.
REQ-024 Addresses SHALL be used modulo the memory depth; there is no out-of-range condition.
REQ-025 The block SHALL contain no register-0 forcing and no bypass logic; those belong to the enclosing register file.

Reset
REQ-026 While rst=1, raddr SHALL be forced asynchronously to 0, so doutb = mem[0].
REQ-027 While rst=1, reads SHALL be ignored.
REQ-028 While rst=1, writes SHALL still be honoured; write enables are not gated by rst.
REQ-029 When rst deasserts, raddr SHALL remain 0 until the next enabled read capture.
REQ-030 An asserted rst in the middle of operation SHALL NOT corrupt memory contents.

Verification
REQ-031 Power-up scenario: read addresses 0, 1, 0xFFF with enb=1 -> doutb = 0 one clk after each.
REQ-032 Full write/readback: ena=1, wea=0xFF, addra=0x005, dina=0x0123456789ABCDEF; then addrb=0x005 -> doutb = 0x0123456789ABCDEF next cycle.
REQ-033 Byte merge: after REQ-032, write wea=0x0F, dina=0xFFFFFFFFFFFFFFFF to 0x005 -> read 0x0123456789ABCDEF becomes 0x01234567FFFFFFFF.
REQ-034 Write disable: repeat the write of REQ-033 with ena=0 -> contents unchanged.
REQ-035 Enables and write-through: hold raddr=0x010 with enb=0 while addrb changes -> doutb stays mem[0x010]; then write 0xAA to all bytes of 0x010 -> doutb = 0xAAAAAAAAAAAAAAAA after that edge.
REQ-036 Reset: assert rst asynchronously mid-cycle -> doutb switches to mem[0] without waiting for a clk edge; previously written address 0x005 still reads back intact after rst deasserts.
